// File: rtl/bsg_fpu_denorm_shift_seq.sv
// Sequential denormalisation shifter. It right-shifts a mantissa one bit per cycle and
// collects the last bit shifted out as guard and the OR of all earlier bits as sticky.
// It leaves the shift loop early once the mantissa and guard are both zero, because
// further shifts cannot change any output.
module bsg_fpu_denorm_shift_seq #(
  parameter int unsigned width_p       = 16,
  parameter int unsigned shamt_width_p = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [width_p-1:0]       mant_i,
  input  logic [shamt_width_p-1:0] shamt_i,

  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [width_p-1:0]       mant_o,
  output logic                     guard_o,
  output logic                     sticky_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [width_p-1:0]         mant_q, mant_d;
  logic                       guard_q, guard_d;
  logic                       sticky_q, sticky_d;
  logic [shamt_width_p-1:0]   rem_q, rem_d;

  // One-bit shift step, computed combinationally from the current registers
  logic [width_p-1:0]         mant_shift;
  logic                       guard_shift;
  logic                       sticky_shift;
  logic [shamt_width_p-1:0]   rem_dec;

  // Next value of every register for a single shift step
  always_comb begin
    mant_shift   = mant_q >> 1;
    guard_shift  = mant_q[0];
    sticky_shift = sticky_q | guard_q;
    rem_dec      = rem_q - shamt_width_p'(1);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    rem_d    = rem_q;
    ready_o  = 1'b0;
    v_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_o = 1'b1;
        if (v_i) begin
          mant_d   = mant_i;
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          rem_d    = shamt_i;
          state_d  = (shamt_i == '0) ? StDone : StShift;
        end
      end

      StShift: begin
        mant_d   = mant_shift;
        guard_d  = guard_shift;
        sticky_d = sticky_shift;
        rem_d    = rem_dec;
        // Once mant and guard are zero, sticky is final and the rest is redundant
        if (rem_dec == '0 || (mant_shift == '0 && !guard_shift)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        v_o = 1'b1;
        if (yumi_i) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset also masks v_i
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      rem_q    <= rem_d;
    end
  end

  // Result outputs always mirror the registers
  always_comb begin
    mant_o   = mant_q;
    guard_o  = guard_q;
    sticky_o = sticky_q;
  end

endmodule

// File: tb/tb_bsg_fpu_denorm_shift_seq.sv
// Directed self-checking bench for bsg_fpu_denorm_shift_seq.
module tb_bsg_fpu_denorm_shift_seq;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 5;

  logic          clk;
  logic          reset_i;
  logic          v_i;
  logic          ready_o;
  logic [W-1:0]  mant_i;
  logic [SW-1:0] shamt_i;
  logic          v_o;
  logic          yumi_i;
  logic [W-1:0]  mant_o;
  logic          guard_o;
  logic          sticky_o;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_fpu_denorm_shift_seq #(
    .width_p       (W),
    .shamt_width_p (SW)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .mant_i   (mant_i),
    .shamt_i  (shamt_i),
    .v_o      (v_o),
    .yumi_i   (yumi_i),
    .mant_o   (mant_o),
    .guard_o  (guard_o),
    .sticky_o (sticky_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer protocol: yumi only while a result is offered
  yumi_legal_a : assert property (@(posedge clk) disable iff (reset_i) yumi_i |-> v_o);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure latency, check result, hold off yumi for `hold` cycles
  task automatic do_op(input string tag, input logic [W-1:0] m, input logic [SW-1:0] s,
                       input int exp_lat, input logic [W-1:0] exp_m, input logic exp_g,
                       input logic exp_s, input int hold);
    int lat;
    check_val({tag, ".ready"}, 32'(ready_o), 32'd1);
    v_i     = 1'b1;
    mant_i  = m;
    shamt_i = s;
    step();
    v_i     = 1'b0;
    mant_i  = '0;
    shamt_i = '0;
    if (exp_lat > 1) check_val({tag, ".busy"}, 32'(ready_o), 32'd0);
    lat = 1;
    while (!v_o && lat < 200) begin
      step();
      lat++;
    end
    check_val({tag, ".lat"},    32'(lat),      32'(exp_lat));
    check_val({tag, ".mant"},   32'(mant_o),   32'(exp_m));
    check_val({tag, ".guard"},  32'(guard_o),  32'(exp_g));
    check_val({tag, ".sticky"}, 32'(sticky_o), 32'(exp_s));
    for (int i = 0; i < hold; i++) begin
      // A new request during DONE must be ignored
      v_i    = 1'b1;
      mant_i = 16'h5A5A;
      step();
      v_i    = 1'b0;
      check_val({tag, ".hold_v"},    32'(v_o),      32'd1);
      check_val({tag, ".hold_rdy"},  32'(ready_o),  32'd0);
      check_val({tag, ".hold_mant"}, 32'(mant_o),   32'(exp_m));
      check_val({tag, ".hold_g"},    32'(guard_o),  32'(exp_g));
      check_val({tag, ".hold_s"},    32'(sticky_o), 32'(exp_s));
    end
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    check_val({tag, ".post_rdy"}, 32'(ready_o), 32'd1);
    check_val({tag, ".post_v"},   32'(v_o),     32'd0);
  endtask

  initial begin
    int stale;
    reset_i = 1'b1;
    v_i     = 1'b1;
    mant_i  = 16'h5555;
    shamt_i = '0;
    yumi_i  = 1'b0;
    step();
    step();
    v_i     = 1'b0;
    reset_i = 1'b0;
    check_val("rst.ready",  32'(ready_o),  32'd1);
    check_val("rst.v",      32'(v_o),      32'd0);
    check_val("rst.mant",   32'(mant_o),   32'd0);
    check_val("rst.guard",  32'(guard_o),  32'd0);
    check_val("rst.sticky", 32'(sticky_o), 32'd0);

    do_op("sh1",    16'h8001, 5'd1,  2,  16'h4000, 1'b1, 1'b0, 0);
    do_op("sh2",    16'h8001, 5'd2,  3,  16'h2000, 1'b0, 1'b1, 0);
    do_op("sh0",    16'h1234, 5'd0,  1,  16'h1234, 1'b0, 1'b0, 0);
    do_op("flush16",16'hFFFF, 5'd16, 17, 16'h0000, 1'b1, 1'b1, 0);
    do_op("flush31",16'hFFFF, 5'd31, 18, 16'h0000, 1'b0, 1'b1, 0);
    do_op("zero",   16'h0000, 5'd10, 2,  16'h0000, 1'b0, 1'b0, 0);
    do_op("a5sh3",  16'hA5A5, 5'd3,  4,  16'h14B4, 1'b1, 1'b1, 0);
    do_op("early20",16'h0100, 5'd20, 11, 16'h0000, 1'b0, 1'b1, 0);
    do_op("bp",     16'h8001, 5'd1,  2,  16'h4000, 1'b1, 1'b0, 5);

    // Reset in the middle of a long shift
    v_i     = 1'b1;
    mant_i  = 16'hFFFF;
    shamt_i = 5'd16;
    step();
    v_i = 1'b0;
    step();
    step();
    step();
    check_val("mid.inshift", 32'(ready_o), 32'd0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_val("mid.ready", 32'(ready_o), 32'd1);
    check_val("mid.v",     32'(v_o),     32'd0);
    check_val("mid.mant",  32'(mant_o),  32'd0);
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (v_o) stale++;
    end
    check_val("mid.nostale", 32'(stale), 32'd0);

    do_op("after_rst", 16'h1234, 5'd0, 1, 16'h1234, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_fpu_denorm_shift_seq.md
BSG_FPU_DENORM_SHIFT_SEQ -- requirements
Module: bsg_fpu_denorm_shift_seq

Interface
REQ-001 SHALL have parameter width_p, default 16: mantissa width in bits, minimum 2.
REQ-002 SHALL have parameter shamt_width_p, default 5: shift-amount width; a value of 31 flushes a 16-bit mantissa completely.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port v_i, input, 1 bit: request valid.
REQ-006 SHALL have port ready_o, output, 1 bit: ready to accept a request.
REQ-007 SHALL have port mant_i, input, width_p bits: unshifted mantissa.
REQ-008 SHALL have port shamt_i, input, shamt_width_p bits: right-shift amount, unsigned.
REQ-009 SHALL have port v_o, output, 1 bit: result valid.
REQ-010 SHALL have port yumi_i, input, 1 bit: consumer takes the result; legal only while v_o=1.
REQ-011 SHALL have port mant_o, output, width_p bits: shifted mantissa.
REQ-012 SHALL have port guard_o, output, 1 bit: last bit shifted out.
REQ-013 SHALL have port sticky_o, output, 1 bit: OR of all bits shifted out before the guard bit.

Function
REQ-014 SHALL implement states IDLE, SHIFT and DONE.
REQ-015 SHALL drive ready_o=1 only in IDLE and v_o=1 only in DONE.
REQ-016 SHALL accept a request in a cycle where v_i&ready_o=1, and SHALL ignore v_i in all other cycles.
REQ-017 On acceptance, SHALL load mant_i into the data register, clear guard and sticky, and load the remaining count with shamt_i.
REQ-018 On acceptance with shamt_i=0, SHALL go to DONE; with shamt_i>0, SHALL go to SHIFT.
REQ-019 Each SHIFT cycle SHALL perform exactly one shift:
  - sticky <= sticky|guard
  - guard <= mant[0]
  - mant <= mant>>1, zero-filled
  - remaining <= remaining-1
REQ-020 SHALL leave SHIFT for DONE at the edge where remaining becomes 0.
REQ-021 SHALL also leave SHIFT for DONE early, at the edge where the new mant and new guard are both 0, because further shifts cannot change any output.
REQ-022 Latency: for acceptance in cycle c, v_o SHALL first be 1 in cycle c+1+k, where k is the number of shifts performed per REQ-020/021.
  - k=shamt_i when there is no early exit.
  - k=0 for shamt_i=0.
REQ-023 Shift amounts >= width_p SHALL be legal; the result SHALL equal an infinite-precision right shift truncated to mant/guard/sticky.
REQ-024 SHALL hold mant_o, guard_o, sticky_o and v_o stable in DONE until yumi_i=1.
REQ-025 On yumi_i=1 in DONE, SHALL go to IDLE; ready_o SHALL be 1 in the following cycle, so there is no same-cycle re-accept.
REQ-026 mant_o, guard_o and sticky_o SHALL be defined only while v_o=1; they SHALL reflect the register contents at all times.
REQ-027 yumi_i=1 while v_o=0 is illegal; the bench SHALL assert on it.

Reset
REQ-028 While reset_i=1 at a clock edge, the block SHALL enter IDLE and clear mant, guard, sticky and remaining to 0.
REQ-029 After reset, ready_o SHALL be 1 and v_o SHALL be 0.
REQ-030 Reset asserted in SHIFT or DONE SHALL abort the operation with no result produced.
REQ-031 v_i SHALL be ignored in any cycle where reset_i=1.

Verification
REQ-032 mant_i=0x8001, shamt_i=1, accepted in cycle c -> v_o=1 in cycle c+2 with mant_o=0x4000, guard_o=1, sticky_o=0.
REQ-033 mant_i=0x8001, shamt_i=2 -> v_o in cycle c+3 with mant_o=0x2000, guard_o=0, sticky_o=1.
REQ-034 mant_i=0x1234, shamt_i=0 -> v_o in cycle c+1 with mant_o=0x1234, guard_o=0, sticky_o=0.
REQ-035 Flush cases:
  - mant_i=0xFFFF, shamt_i=16 -> v_o at c+17; mant_o=0, guard_o=1, sticky_o=1.
  - mant_i=0xFFFF, shamt_i=31 -> early exit after 17 shifts, v_o at c+18; mant_o=0, guard_o=0, sticky_o=1.
REQ-036 Early exit: mant_i=0x0000, shamt_i=10 -> v_o at c+2; all outputs 0.
REQ-037 Backpressure and reset:
  - Hold yumi_i=0 for 5 cycles in DONE -> outputs stable and ready_o=0 throughout.
  - Assert reset_i mid-SHIFT -> next cycle ready_o=1, v_o=0, and no stale result appears.
